sdram_init_monitor: RTL

//  Passive receiver for the SDRAM power-up command stream {cs_n,ras_n,cas_n,we_n}/ba/addr driven by the init controller.

---
 rtl/sdram_mon_pkg.sv | 57 +++++
 rtl/sdram_mon_gap_cnt.sv | 41 ++++
 rtl/sdram_init_monitor.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_mon_pkg
//  Description : Shared definitions for the SDRAM power-up sequence monitor:
//                command encodings {cs_n,ras_n,cas_n,we_n}, monitor states,
//                violation codes, default timing constants and small decode
//                helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_mon_pkg;

    // Command encodings as seen on {cs_n,ras_n,cas_n,we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    // Default timing, in clock cycles
    localparam logic [14:0] DEF_T_POWER  = 15'd20_000;
    localparam logic [3:0]  DEF_AREF_NUM = 4'd8;
    localparam logic [2:0]  DEF_TRP_NOP  = 3'd2;
    localparam logic [2:0]  DEF_TRC_NOP  = 3'd7;
    localparam logic [2:0]  DEF_TMRD_NOP = 3'd3;

    typedef enum logic [2:0] {
        MON_PWR  = 3'd0,
        MON_TRP  = 3'd1,
        MON_AREF = 3'd2,
        MON_TRC  = 3'd3,
        MON_TMRD = 3'd4,
        MON_DONE = 3'd5,
        MON_ERR  = 3'd6
    } mon_state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_EARLY    = 3'd1,
        ERR_ILLEGAL  = 3'd2,
        ERR_TRP      = 3'd3,
        ERR_TRC      = 3'd4,
        ERR_TMRD     = 3'd5,
        ERR_BAD_MODE = 3'd6
    } mon_err_t;

    // NOP, or deselect (cs_n high) regardless of the other three lines
    function automatic logic cmd_is_idle(input logic [3:0] cmd);
        return cmd[3] || (cmd == CMD_NOP);
    endfunction

    // CAS latency must be 2 or 3; burst lengths 4..6 are reserved encodings
    function automatic logic mode_is_legal(input logic [2:0] bl, input logic [2:0] cas);
        return ((cas == 3'd2) || (cas == 3'd3)) &&
               !((bl == 3'd4) || (bl == 3'd5) || (bl == 3'd6));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_mon_gap_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_mon_gap_cnt
//  Description : 3-bit idle-gap counter. Cleared when a command is accepted,
//                counts idle cycles afterwards (saturating at 7) and flags
//                when the count has reached the selected minimum.
//  Ports       : sys_clk, sys_rst_n (async, active-low)
//                i_clear  - restart the gap count
//                i_idle   - current command is NOP/deselect
//                i_min    - minimum idle cycles required
//                o_cnt    - current idle count
//                o_ge_min - o_cnt >= i_min
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_mon_gap_cnt (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       i_clear,
    input  logic       i_idle,
    input  logic [2:0] i_min,
    output logic [2:0] o_cnt,
    output logic       o_ge_min
);

    logic [2:0] r_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= 3'd0;
        end else if (i_clear) begin
            r_cnt <= 3'd0;
        end else if (i_idle && (r_cnt != 3'd7)) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_ge_min = (r_cnt >= i_min);

endmodule
`default_nettype wire

// File: rtl/sdram_init_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_init_monitor
//  Description : Passive monitor of the SDRAM power-up command stream. Checks
//                the power-up wait, precharge-all, refresh count, mode
//                register set and inter-command idle gaps; captures the
//                decoded mode register and reports completion or the first
//                violation.
//  Config      : SDRAM_MON_TIMING_CHK_EN - when defined, idle-gap checking
//                after PRE/AREF/MRS is built in (codes 3/4/5). When undefined
//                the next legal command is accepted immediately and
//                init_done rises the cycle after MRS is accepted.
//  Ports       : sys_clk, sys_rst_n (async, active-low)
//                cmd_in[3:0] {cs_n,ras_n,cas_n,we_n}, ba_in[1:0], addr_in[12:0]
//                init_done, aref_cnt[3:0], mr_burst_len[2:0], mr_burst_type,
//                mr_cas_lat[2:0], mr_wr_single, err_valid, err_code[2:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_init_monitor
    import sdram_mon_pkg::*;
#(
    parameter logic [14:0] T_POWER  = DEF_T_POWER,
    parameter logic [3:0]  AREF_NUM = DEF_AREF_NUM
`ifdef SDRAM_MON_TIMING_CHK_EN
    ,
    parameter logic [2:0]  TRP_NOP  = DEF_TRP_NOP,
    parameter logic [2:0]  TRC_NOP  = DEF_TRC_NOP,
    parameter logic [2:0]  TMRD_NOP = DEF_TMRD_NOP
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  cmd_in,
    input  logic [1:0]  ba_in,
    input  logic [12:0] addr_in,
    output logic        init_done,
    output logic [3:0]  aref_cnt,
    output logic [2:0]  mr_burst_len,
    output logic        mr_burst_type,
    output logic [2:0]  mr_cas_lat,
    output logic        mr_wr_single,
    output logic        err_valid,
    output logic [2:0]  err_code
);

    mon_state_t  r_state;
    mon_state_t  w_state_nxt;
    mon_err_t    w_err_nxt;

    logic [14:0] r_cnt_pwr;
    logic [3:0]  r_aref_cnt;
    logic [2:0]  r_mr_bl;
    logic        r_mr_bt;
    logic [2:0]  r_mr_cas;
    logic        r_mr_ws;
    logic        r_err_valid;
    logic [2:0]  r_err_code;

    logic        w_idle;
    logic        w_gap_ge;
    logic        w_tmrd_reach;
    logic        w_aref_phase;
    logic        w_mrs_fmt_ok;
    logic        w_mode_ok;
    logic        w_aref_inc;
    logic        w_mrs_cap;

    assign w_idle = cmd_is_idle(cmd_in);

`ifdef SDRAM_MON_TIMING_CHK_EN
    localparam mon_state_t ST_AFTER_PRE  = MON_TRP;
    localparam mon_state_t ST_AFTER_AREF = MON_TRC;
    localparam mon_state_t ST_AFTER_MRS  = MON_TMRD;

    logic [2:0] w_gap_min;
    logic [2:0] w_gap_cnt;
    logic       w_gap_clear;

    always_comb begin : p_gap_min
        w_gap_min = TMRD_NOP;
        case (r_state)
            MON_TRP: w_gap_min = TRP_NOP;
            MON_TRC: w_gap_min = TRC_NOP;
            default: w_gap_min = TMRD_NOP;
        endcase
    end

    // Every non-idle command that does not error is an accepted command,
    // and every accepted command opens a new idle gap.
    assign w_gap_clear = !w_idle && (w_err_nxt == ERR_NONE);

    sdram_mon_gap_cnt u_gap_cnt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_clear   (w_gap_clear),
        .i_idle    (w_idle),
        .i_min     (w_gap_min),
        .o_cnt     (w_gap_cnt),
        .o_ge_min  (w_gap_ge)
    );

    // The idle being sampled now is the TMRD_NOP-th one, so completion is
    // registered on this edge.
    assign w_tmrd_reach = w_idle && (({1'b0, w_gap_cnt} + 4'd1) >= {1'b0, TMRD_NOP});
`else
    localparam mon_state_t ST_AFTER_PRE  = MON_AREF;
    localparam mon_state_t ST_AFTER_AREF = MON_AREF;
    localparam mon_state_t ST_AFTER_MRS  = MON_DONE;

    assign w_gap_ge     = 1'b1;
    assign w_tmrd_reach = 1'b0;
`endif

    // Refresh/MRS decisions apply in MON_AREF, and in the post-PRE/AREF
    // gap states once their idle gap has been satisfied.
    assign w_aref_phase = !w_idle &&
                          ((r_state == MON_AREF) ||
                           (((r_state == MON_TRP) || (r_state == MON_TRC)) && w_gap_ge));

    assign w_mrs_fmt_ok = (ba_in == 2'b00) && (addr_in[12:10] == 3'b000) &&
                          (addr_in[8:7] == 2'b00) && (r_aref_cnt >= AREF_NUM);

    assign w_mode_ok = mode_is_legal(addr_in[2:0], addr_in[6:4]);

    // ---------------------------------------------------------------- state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= MON_PWR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin : p_next_state
        w_state_nxt = r_state;
        w_err_nxt   = ERR_NONE;
        w_aref_inc  = 1'b0;
        w_mrs_cap   = 1'b0;

        case (r_state)
            MON_PWR: begin
                if (!w_idle) begin
                    if (r_cnt_pwr < T_POWER) begin
                        w_err_nxt = ERR_EARLY;
                    end else if ((cmd_in == CMD_PRE) && addr_in[10]) begin
                        w_state_nxt = ST_AFTER_PRE;
                    end else begin
                        w_err_nxt = ERR_ILLEGAL;
                    end
                end
            end
            MON_TRP: begin
                if (!w_idle && !w_gap_ge) begin
                    w_err_nxt = ERR_TRP;
                end
            end
            MON_TRC: begin
                if (!w_idle && !w_gap_ge) begin
                    w_err_nxt = ERR_TRC;
                end
            end
            MON_TMRD: begin
                if (!w_idle && !w_gap_ge) begin
                    w_err_nxt = ERR_TMRD;
                end else if (w_gap_ge || w_tmrd_reach) begin
                    w_state_nxt = MON_DONE;
                end
            end
            default: begin
                // MON_AREF is handled below; MON_DONE and MON_ERR hold.
            end
        endcase

        if (w_aref_phase) begin
            if (cmd_in == CMD_AREF) begin
                w_aref_inc  = 1'b1;
                w_state_nxt = ST_AFTER_AREF;
            end else if ((cmd_in == CMD_MRS) && w_mrs_fmt_ok) begin
                // Fields are captured even when the mode itself is rejected.
                w_mrs_cap = 1'b1;
                if (w_mode_ok) begin
                    w_state_nxt = ST_AFTER_MRS;
                end else begin
                    w_err_nxt = ERR_BAD_MODE;
                end
            end else begin
                w_err_nxt = ERR_ILLEGAL;
            end
        end

        // An erroring command never advances the sequence.
        if (w_err_nxt != ERR_NONE) begin
            w_state_nxt = MON_ERR;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin : p_outputs
        init_done = (r_state == MON_DONE);
        err_valid = r_err_valid;
        err_code  = r_err_code;
    end

    assign aref_cnt      = r_aref_cnt;
    assign mr_burst_len  = r_mr_bl;
    assign mr_burst_type = r_mr_bt;
    assign mr_cas_lat    = r_mr_cas;
    assign mr_wr_single  = r_mr_ws;

    // --------------------------------------------------------- datapath regs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_pwr   <= 15'd0;
            r_aref_cnt  <= 4'd0;
            r_mr_bl     <= 3'd0;
            r_mr_bt     <= 1'b0;
            r_mr_cas    <= 3'd0;
            r_mr_ws     <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= 3'd0;
        end else begin
            if (r_cnt_pwr != T_POWER) begin
                r_cnt_pwr <= r_cnt_pwr + 15'd1;
            end
            if (w_aref_inc && (r_aref_cnt != 4'd15)) begin
                r_aref_cnt <= r_aref_cnt + 4'd1;
            end
            if (w_mrs_cap) begin
                r_mr_bl  <= addr_in[2:0];
                r_mr_bt  <= addr_in[3];
                r_mr_cas <= addr_in[6:4];
                r_mr_ws  <= addr_in[9];
            end
            // Errors are only raised outside MON_ERR, so this pulses once.
            r_err_valid <= (w_err_nxt != ERR_NONE);
            if ((w_err_nxt != ERR_NONE) && (r_err_code == 3'd0)) begin
                r_err_code <= w_err_nxt;
            end
        end
    end

endmodule
`default_nettype wire
